// File: rtl/sdram_wr_burst.sv
// SDRAM write-burst engine: requests the bus, opens a row, streams gapless BURST_LEN
// write bursts from a FWFT FIFO, then precharges and hands the bus back.
module sdram_wr_burst #(
  parameter int DQ_W      = 16,
  parameter int ROW_W     = 12,
  parameter int COL_W     = 9,
  parameter int BANK_W    = 2,
  parameter int BURST_LEN = 4,
  parameter int T_RCD     = 2,
  parameter int T_WR      = 2,
  parameter int T_RP      = 2
) (
  input  logic              sclk,
  input  logic              s_rst,
  input  logic              wr_trig,
  input  logic              wr_en,
  input  logic              ref_req,
  input  logic [DQ_W-1:0]   wr_data,
  output logic              wr_data_rd,
  output logic              wr_req,
  output logic              flag_wr_end,
  output logic [3:0]        sdram_cmd,
  output logic [ROW_W-1:0]  sdram_addr,
  output logic [BANK_W-1:0] sdram_bank,
  output logic [DQ_W-1:0]   sdram_dq,
  output logic              sdram_dq_oe,
  output logic [3:0]        dbg_state
);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;

  localparam int CW = 8;
  localparam logic [CW-1:0] BEAT_LAST = CW'(BURST_LEN - 1);
  localparam logic [CW-1:0] RCD_LAST  = CW'((T_RCD >= 2) ? T_RCD - 2 : 0);
  localparam logic [CW-1:0] WR_LAST   = CW'(T_WR - 1);
  localparam logic [CW-1:0] RP_LAST   = CW'((T_RP >= 2) ? T_RP - 2 : 0);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_REQ   = 4'd1,
    S_ACT   = 4'd2,
    S_RCD   = 4'd3,
    S_WRITE = 4'd4,
    S_RECOV = 4'd5,
    S_PRE   = 4'd6,
    S_RP    = 4'd7,
    S_END   = 4'd8
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [BANK_W-1:0] open_bank_q, open_bank_d;
  logic              ref_pend_q, ref_pend_d;

  logic [3:0]        cmd_q, cmd_d;
  logic [ROW_W-1:0]  addr_q, addr_d;
  logic [BANK_W-1:0] sbank_q, sbank_d;
  logic [DQ_W-1:0]   dq_q, dq_d;
  logic              oe_q, oe_d;
  logic              req_q, req_d;
  logic              flag_q, flag_d;

  logic [COL_W:0]    col_sum;
  logic              col_wrap, last_beat, burst_cont;

  assign col_sum    = {1'b0, col_q} + (COL_W+1)'(BURST_LEN);
  assign col_wrap   = col_sum[COL_W];
  assign last_beat  = (state_q == S_WRITE) && (cnt_q == BEAT_LAST);
  // A refresh seen anywhere since the request ends the session at the next burst boundary.
  assign burst_cont = wr_trig && !ref_req && !ref_pend_q && !col_wrap;

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      bank_q      <= '0;
      open_bank_q <= '0;
      ref_pend_q  <= 1'b0;
      cmd_q       <= CMD_NOP;
      addr_q      <= '0;
      sbank_q     <= '0;
      dq_q        <= '0;
      oe_q        <= 1'b0;
      req_q       <= 1'b0;
      flag_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      bank_q      <= bank_d;
      open_bank_q <= open_bank_d;
      ref_pend_q  <= ref_pend_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      sbank_q     <= sbank_d;
      dq_q        <= dq_d;
      oe_q        <= oe_d;
      req_q       <= req_d;
      flag_q      <= flag_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    col_d       = col_q;
    row_d       = row_q;
    bank_d      = bank_q;
    open_bank_d = open_bank_q;
    ref_pend_d  = ref_pend_q;
    case (state_q)
      S_IDLE: begin
        ref_pend_d = 1'b0;
        if (wr_trig) state_d = S_REQ;
      end
      S_REQ: begin
        if (wr_en) begin
          state_d     = S_ACT;
          open_bank_d = bank_q;
        end
      end
      S_ACT: begin
        cnt_d   = '0;
        state_d = (T_RCD == 1) ? S_WRITE : S_RCD;
      end
      S_RCD: begin
        if (cnt_q == RCD_LAST) begin
          cnt_d   = '0;
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WRITE: begin
        if (last_beat) begin
          cnt_d = '0;
          col_d = col_sum[COL_W-1:0];
          if (col_wrap) begin
            row_d = row_q + ROW_W'(1);
            if (row_q == '1) bank_d = bank_q + BANK_W'(1);
          end
          state_d = burst_cont ? S_WRITE : S_RECOV;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RECOV: begin
        if (cnt_q == WR_LAST) begin
          cnt_d   = '0;
          state_d = S_PRE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PRE: begin
        cnt_d   = '0;
        state_d = (T_RP == 1) ? S_END : S_RP;
      end
      S_RP: begin
        if (cnt_q == RP_LAST) state_d = S_END;
        else                  cnt_d   = cnt_q + CW'(1);
      end
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (ref_req && (state_q inside {S_REQ, S_ACT, S_RCD, S_WRITE})) ref_pend_d = 1'b1;
  end

  // Outputs are decoded from the next state and registered, so they line up with state_q.
  always_comb begin
    cmd_d   = CMD_NOP;
    addr_d  = '0;
    sbank_d = '0;
    dq_d    = '0;
    oe_d    = 1'b0;
    req_d   = 1'b0;
    flag_d  = 1'b0;
    case (state_d)
      S_REQ: req_d = 1'b1;
      S_ACT: begin
        cmd_d   = CMD_ACT;
        addr_d  = row_q;
        sbank_d = bank_q;
      end
      S_WRITE: begin
        oe_d = 1'b1;
        dq_d = wr_data;
        if (cnt_d == '0) begin
          cmd_d   = CMD_WR;
          addr_d  = ROW_W'(col_d);
          sbank_d = open_bank_q;
        end
      end
      S_PRE: begin
        cmd_d   = CMD_PRE;
        sbank_d = open_bank_q;
      end
      S_END:   flag_d = 1'b1;
      default: ;
    endcase
  end

  // FIFO pop is the one decoded strobe: the head word is latched into dq on this edge.
  assign wr_data_rd  = (state_d == S_WRITE);
  assign wr_req      = req_q;
  assign flag_wr_end = flag_q;
  assign sdram_cmd   = cmd_q;
  assign sdram_addr  = addr_q;
  assign sdram_bank  = sbank_q;
  assign sdram_dq    = dq_q;
  assign sdram_dq_oe = oe_q;
  assign dbg_state   = state_q;

endmodule
